// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating icache fetches and LSB loads/stores onto one RAM/IO port.
// Optional IO write back-pressure is enabled by defining MEM_IO_STALL_EN.
module mem_ctrl #(
  parameter int unsigned       ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = 'h30000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  input  logic              jump,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_done,
  output logic [31:0]       ic_data,
  input  logic              lsb_req,
  input  logic              lsb_wr,
  input  logic [1:0]        lsb_len,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [31:0]       lsb_wdata,
  output logic              lsb_done,
  output logic [31:0]       lsb_rdata,
  input  logic [7:0]        mem_din,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;
  typedef enum logic {OWN_IC, OWN_LSB} owner_t;

  state_t            state_q;
  owner_t            owner_q, last_owner_q;
  logic [1:0]        cnt_q, n_q;
  logic [31:0]       data_q;
  logic [23:0]       wdata_q;
  logic [ADDR_W-1:0] mem_a_q;
  logic [7:0]        mem_dout_q;
  logic              mem_wr_q;
  logic              ic_done_q, lsb_done_q;
  logic [31:0]       ic_data_q, lsb_rdata_q;

  logic        ic_p, lsb_p, grant_lsb, stall_w;
  logic [31:0] rd_word;

  // A requester whose done pulse is still visible has already been served.
  assign ic_p      = ic_req & ~ic_done_q & ~jump;
  assign lsb_p     = lsb_req & ~lsb_done_q;
  assign grant_lsb = lsb_p & (~ic_p | (last_owner_q == OWN_IC));

`ifdef MEM_IO_STALL_EN
  assign stall_w = (state_q == S_WRITE) && (mem_a_q >= IO_BASE) && io_buffer_full;
`else
  logic unused_ok;
  assign stall_w   = 1'b0;
  assign unused_ok = &{1'b0, io_buffer_full, IO_BASE[0]};
`endif

  // Final read word: last byte comes straight from mem_din, bytes beyond n are zero.
  always_comb begin
    rd_word = data_q;
    rd_word[8*cnt_q +: 8] = mem_din;
    case (n_q)
      2'd0:    rd_word[31:8]  = '0;
      2'd1:    rd_word[31:16] = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_IC;
      last_owner_q <= OWN_LSB;
      cnt_q        <= '0;
      n_q          <= '0;
      data_q       <= '0;
      wdata_q      <= '0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      mem_wr_q     <= 1'b0;
      ic_done_q    <= 1'b0;
      lsb_done_q   <= 1'b0;
      ic_data_q    <= '0;
      lsb_rdata_q  <= '0;
    end else if (ready) begin
      ic_done_q  <= 1'b0;
      lsb_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ic_p || lsb_p) begin
            cnt_q <= '0;
            if (grant_lsb) begin
              owner_q      <= OWN_LSB;
              last_owner_q <= OWN_LSB;
              mem_a_q      <= lsb_addr;
              n_q          <= lsb_len;
              if (lsb_wr) begin
                mem_dout_q <= lsb_wdata[7:0];
                wdata_q    <= lsb_wdata[31:8];
                mem_wr_q   <= 1'b1;
                state_q    <= S_WRITE;
              end else begin
                mem_wr_q <= 1'b0;
                state_q  <= S_READ;
              end
            end else begin
              owner_q      <= OWN_IC;
              last_owner_q <= OWN_IC;
              mem_a_q      <= ic_addr;
              n_q          <= 2'd3;
              mem_wr_q     <= 1'b0;
              state_q      <= S_READ;
            end
          end
        end
        S_READ: begin
          if (jump) begin
            mem_wr_q <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            data_q[8*cnt_q +: 8] <= mem_din;
            if (cnt_q == n_q) begin
              state_q <= S_IDLE;
              if (owner_q == OWN_IC) begin
                ic_done_q <= 1'b1;
                ic_data_q <= rd_word;
              end else begin
                lsb_done_q  <= 1'b1;
                lsb_rdata_q <= rd_word;
              end
            end else begin
              cnt_q   <= cnt_q + 2'd1;
              mem_a_q <= mem_a_q + ADDR_W'(1);
            end
          end
        end
        S_WRITE: begin
          if (!stall_w) begin
            if (cnt_q == n_q) begin
              mem_wr_q   <= 1'b0;
              lsb_done_q <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              cnt_q      <= cnt_q + 2'd1;
              mem_a_q    <= mem_a_q + ADDR_W'(1);
              mem_dout_q <= wdata_q[7:0];
              wdata_q    <= {8'h00, wdata_q[23:8]};
              mem_wr_q   <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  assign mem_wr    = mem_wr_q & ~stall_w;
  assign ic_done   = ic_done_q;
  assign ic_data   = ic_data_q;
  assign lsb_done  = lsb_done_q;
  assign lsb_rdata = lsb_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a combinational byte RAM model and a write log.
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        reset, ready, jump;
  logic        ic_req, ic_done, lsb_req, lsb_wr, lsb_done, mem_wr, io_buffer_full;
  logic [31:0] ic_addr, ic_data, lsb_addr, lsb_wdata, lsb_rdata, mem_a;
  logic [1:0]  lsb_len;
  logic [7:0]  mem_din, mem_dout;

  int checks = 0;
  int errors = 0;
  logic [39:0] wlog[$];

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(32), .IO_BASE(32'h30000)) dut (
    .clk(clk), .reset(reset), .ready(ready), .jump(jump),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_data(ic_data),
    .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_len(lsb_len), .lsb_addr(lsb_addr),
    .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .mem_din(mem_din), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  // RAM contents: a fetchable NOP word at 0x1000, elsewhere address-derived bytes.
  always_comb begin
    case (mem_a)
      32'h1000:                   mem_din = 8'h13;
      32'h1001, 32'h1002, 32'h1003: mem_din = 8'h00;
      default:                    mem_din = mem_a[7:0] ^ 8'hA5;
    endcase
  end

  always @(posedge clk) if (reset && ready && mem_wr) wlog.push_back({mem_a, mem_dout});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_lsb_done(input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (lsb_done) begin
        cyc = i;
        return;
      end
    end
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] len,
                         input logic [31:0] exp);
    int cyc;
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_len = len; lsb_addr = addr;
    wait_lsb_done(20, cyc);
    check({tag, "_lat"}, 64'(cyc), 64'(int'(len) + 2));
    check({tag, "_data"}, 64'(lsb_rdata), 64'(exp));
    lsb_req = 1'b0;
    tick();
    check({tag, "_pulse"}, 64'(lsb_done), 64'd0);
  endtask

  initial begin
    int cyc, dones, wr_seen;
    int tix[$];
    logic who[$];
    reset = 1'b0; ready = 1'b1; jump = 1'b0; io_buffer_full = 1'b0;
    ic_req = 1'b0; ic_addr = '0; lsb_req = 1'b0; lsb_wr = 1'b0; lsb_len = '0;
    lsb_addr = '0; lsb_wdata = '0;
    tick(); tick();
    check("rst_mem_wr", 64'(mem_wr), 64'd0);
    check("rst_mem_a", 64'(mem_a), 64'd0);
    check("rst_done", 64'({ic_done, lsb_done}), 64'd0);
    check("rst_ic_data", 64'(ic_data), 64'd0);
    reset = 1'b1;
    tick();

    // Instruction fetch at 0x1000
    ic_req = 1'b1; ic_addr = 32'h1000;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("fetch_mem_a", 64'(mem_a), 64'(32'h1000 + i));
      check("fetch_early_done", 64'({ic_done, mem_wr}), 64'd0);
    end
    tick();
    check("fetch_done", 64'(ic_done), 64'd1);
    check("fetch_data", 64'(ic_data), 64'h13);
    ic_req = 1'b0;
    tick();
    check("fetch_pulse", 64'(ic_done), 64'd0);

    // Two-byte store
    wlog.delete();
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_len = 2'd1; lsb_addr = 32'h20; lsb_wdata = 32'h0000BEEF;
    tick();
    check("st_b0", 64'({mem_wr, mem_a, mem_dout}), 64'({1'b1, 32'h20, 8'hEF}));
    tick();
    check("st_b1", 64'({mem_wr, mem_a, mem_dout}), 64'({1'b1, 32'h21, 8'hBE}));
    check("st_early_done", 64'(lsb_done), 64'd0);
    tick();
    check("st_done", 64'({lsb_done, mem_wr}), 64'b10);
    lsb_req = 1'b0;
    tick();
    check("st_pulse", 64'(lsb_done), 64'd0);
    check("st_log_n", 64'(wlog.size()), 64'd2);
    if (wlog.size() == 2) begin
      check("st_log0", 64'(wlog[0]), 64'({32'h20, 8'hEF}));
      check("st_log1", 64'(wlog[1]), 64'({32'h21, 8'hBE}));
    end

    // Loads of each legal length, including wrap at the top of the address space
    do_load("ld4", 32'h40, 2'd3, 32'hE6E7E4E5);
    do_load("ld1", 32'h7F, 2'd0, 32'h000000DA);
    do_load("ld2", 32'h50, 2'd1, 32'h0000F4F5);
    do_load("ldwrap", 32'hFFFFFFFE, 2'd3, 32'hA4A55A5B);
    check("wrap_mem_a", 64'(mem_a), 64'd1);

    // ready low freezes an in-flight load
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_len = 2'd1; lsb_addr = 32'h50;
    tick();
    ready = 1'b0;
    tick(); tick();
    check("rdy_hold_a", 64'(mem_a), 64'h50);
    check("rdy_hold_done", 64'(lsb_done), 64'd0);
    ready = 1'b1;
    tick();
    check("rdy_resume_a", 64'(mem_a), 64'h51);
    tick();
    check("rdy_done", 64'({lsb_done, lsb_rdata}), 64'({1'b1, 32'h0000F4F5}));
    lsb_req = 1'b0;
    tick();

    // jump in the second cycle of a fetch aborts it
    ic_req = 1'b1; ic_addr = 32'h1000;
    tick(); tick();
    jump = 1'b1;
    tick();
    check("jmp_abort", 64'({ic_done, mem_wr}), 64'd0);
    jump = 1'b0; ic_req = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ic_done) dones++;
    end
    check("jmp_no_done", 64'(dones), 64'd0);
    do_load("jmp_idle", 32'h7F, 2'd0, 32'h000000DA);

    // jump never disturbs a store
    wlog.delete();
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_len = 2'd3; lsb_addr = 32'h100; lsb_wdata = 32'h11223344;
    tick(); tick();
    jump = 1'b1;
    tick(); tick();
    jump = 1'b0;
    tick();
    check("jst_done", 64'(lsb_done), 64'd1);
    lsb_req = 1'b0;
    tick();
    check("jst_log_n", 64'(wlog.size()), 64'd4);
    if (wlog.size() == 4) begin
      check("jst_log0", 64'(wlog[0]), 64'({32'h100, 8'h44}));
      check("jst_log3", 64'(wlog[3]), 64'({32'h103, 8'h11}));
    end

`ifdef MEM_IO_STALL_EN
    wlog.delete();
    io_buffer_full = 1'b1;
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_len = 2'd0; lsb_addr = 32'h30000; lsb_wdata = 32'h5A;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("io_stall_wr", 64'({mem_wr, lsb_done}), 64'd0);
    end
    tick();
    io_buffer_full = 1'b0;
    #1;
    check("io_resume_wr", 64'(mem_wr), 64'd1);
    tick();
    check("io_done", 64'(lsb_done), 64'd1);
    lsb_req = 1'b0;
    tick();
    check("io_log_n", 64'(wlog.size()), 64'd1);
`endif

    // Asynchronous reset in the middle of a store
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_len = 2'd3; lsb_addr = 32'h200; lsb_wdata = 32'hAABBCCDD;
    tick(); tick();
    check("rstw_active", 64'(mem_wr), 64'd1);
    reset = 1'b0;
    #1;
    check("rstw_outs", 64'({mem_wr, lsb_done, mem_a, mem_dout}), 64'd0);
    lsb_req = 1'b0;
    tick();
    reset = 1'b1;
    dones = 0; wr_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (lsb_done) dones++;
      if (mem_wr) wr_seen++;
    end
    check("rstw_quiet", 64'({dones[7:0], wr_seen[7:0]}), 64'd0);

    // Both requesters held after reset: IC, LSB, IC
    reset = 1'b0;
    tick();
    reset = 1'b1;
    ic_req = 1'b1; ic_addr = 32'h1000;
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_len = 2'd0; lsb_addr = 32'h7F;
    for (int t = 1; t <= 40 && tix.size() < 3; t++) begin
      tick();
      if (ic_done && lsb_done) check("arb_both_done", 64'd1, 64'd0);
      if (ic_done)  begin tix.push_back(t); who.push_back(1'b0); end
      if (lsb_done) begin tix.push_back(t); who.push_back(1'b1); end
    end
    ic_req = 1'b0; lsb_req = 1'b0;
    check("arb_count", 64'(tix.size()), 64'd3);
    if (tix.size() >= 3) begin
      check("arb_order", 64'({who[0], who[1], who[2]}), 64'b010);
      check("arb_times", 64'({tix[0][7:0], tix[1][7:0], tix[2][7:0]}), 64'h05070C);
    end
    check("arb_lsb_data", 64'(lsb_rdata), 64'hDA);
    tick();
    check("arb_pulse", 64'({ic_done, lsb_done}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
